// File: rtl/param_updown_counter.sv
// Loadable up/down event counter: modulus MAX_VAL+1, wrap or saturate at the ends,
// registered terminal-count pulse and sticky overflow flag. Define PARAM_UPDOWN_COUNTER_SVA_EN for embedded assertions.
module param_updown_counter #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SAT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // At a boundary the step is never computed, so the value stays inside 0..MAX_VAL.
  function automatic logic [WIDTH-1:0] boundary_next(input logic [WIDTH-1:0] cur,
                                                     input logic             dir_up);
    if (SAT) return cur;
    return dir_up ? '0 : MAX_C;
  endfunction

  assign boundary = en && !load && (up ? (count_q == MAX_C) : (count_q == '0));

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = clamp_load(din);
    end else if (en) begin
      if (boundary) begin
        count_d = boundary_next(count_q, up);
        tc_d    = 1'b1;
      end else begin
        count_d = up ? (count_q + ONE_C) : (count_q - ONE_C);
      end
    end
    // Set wins over clear when both happen on the same edge.
    if (boundary)     ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

`ifdef PARAM_UPDOWN_COUNTER_SVA_EN
  a_reset: assert property (@(posedge clk)
    rst |=> (count == '0) && !ovf && !tc);
  a_load: assert property (@(posedge clk) disable iff (rst)
    load |=> count == (($past(din) > MAX_C) ? MAX_C : $past(din)));
  a_step_up: assert property (@(posedge clk) disable iff (rst)
    (en && !load && up && (count != MAX_C)) |=> count == $past(count) + ONE_C);
  a_step_down: assert property (@(posedge clk) disable iff (rst)
    (en && !load && !up && (count != '0)) |=> count == $past(count) - ONE_C);
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (!en && !load) |=> $stable(count));
  a_range: assert property (@(posedge clk) disable iff (rst)
    count <= MAX_C);
  a_boundary: assert property (@(posedge clk) disable iff (rst)
    boundary |=> tc && ovf);
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (WIDTH=4, MAX_VAL=9): one wrap and one
// saturate instance share the same stimulus and are checked against hand-computed values.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, load, up, ovf_clr;
  logic [3:0] din;
  logic [3:0] count_w, count_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .up(up), .ovf_clr(ovf_clr),
    .count(count_w), .tc(tc_w), .ovf(ovf_w)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .up(up), .ovf_clr(ovf_clr),
    .count(count_s), .tc(tc_s), .ovf(ovf_s)
  );

  typedef struct {
    logic       rst, en, load;
    logic [3:0] din;
    logic       up, clr;
    logic [3:0] c_w; logic tc_w; logic ovf_w;
    logic [3:0] c_s; logic tc_s; logic ovf_s;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l, input logic [3:0] d,
                      input logic u, input logic c);
    rst = r; en = e; load = l; din = d; up = u; ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx,
                           input int cw, input int tw, input int ow,
                           input int cs, input int ts, input int os);
    check({tag, "_wrap_count"}, idx, int'(count_w), cw);
    check({tag, "_wrap_tc"},    idx, int'(tc_w),    tw);
    check({tag, "_wrap_ovf"},   idx, int'(ovf_w),   ow);
    check({tag, "_sat_count"},  idx, int'(count_s), cs);
    check({tag, "_sat_tc"},     idx, int'(tc_s),    ts);
    check({tag, "_sat_ovf"},    idx, int'(ovf_s),   os);
  endtask

  initial begin
    //           rst en ld din up clr | wrap c tc ovf | sat c tc ovf
    vecs[0]  = '{1, 1, 1, 4'd5,  1, 0,  4'd0, 0, 0,  4'd0, 0, 0}; // reset beats load/en
    vecs[1]  = '{1, 1, 1, 4'd5,  1, 0,  4'd0, 0, 0,  4'd0, 0, 0};
    vecs[2]  = '{0, 0, 1, 4'd13, 1, 0,  4'd9, 0, 0,  4'd9, 0, 0}; // load clamp
    vecs[3]  = '{0, 0, 1, 4'd3,  1, 0,  4'd3, 0, 0,  4'd3, 0, 0};
    vecs[4]  = '{0, 0, 0, 4'd0,  1, 0,  4'd3, 0, 0,  4'd3, 0, 0}; // hold
    vecs[5]  = '{0, 0, 1, 4'd8,  1, 0,  4'd8, 0, 0,  4'd8, 0, 0};
    vecs[6]  = '{0, 1, 0, 4'd0,  1, 0,  4'd9, 0, 0,  4'd9, 0, 0};
    vecs[7]  = '{0, 1, 0, 4'd0,  1, 0,  4'd0, 1, 1,  4'd9, 1, 1}; // up boundary
    vecs[8]  = '{0, 1, 0, 4'd0,  1, 0,  4'd1, 0, 1,  4'd9, 1, 1};
    vecs[9]  = '{0, 0, 0, 4'd0,  1, 0,  4'd1, 0, 1,  4'd9, 0, 1}; // hold drops tc
    vecs[10] = '{0, 0, 0, 4'd0,  1, 1,  4'd1, 0, 0,  4'd9, 0, 0}; // ovf_clr
    vecs[11] = '{0, 0, 1, 4'd1,  0, 0,  4'd1, 0, 0,  4'd1, 0, 0};
    vecs[12] = '{0, 1, 0, 4'd0,  0, 0,  4'd0, 0, 0,  4'd0, 0, 0};
    vecs[13] = '{0, 1, 0, 4'd0,  0, 0,  4'd9, 1, 1,  4'd0, 1, 1}; // down boundary
    vecs[14] = '{0, 1, 0, 4'd0,  0, 1,  4'd8, 0, 0,  4'd0, 1, 1}; // sat: set beats clr
    vecs[15] = '{0, 0, 0, 4'd0,  0, 1,  4'd8, 0, 0,  4'd0, 0, 0};
    vecs[16] = '{0, 0, 1, 4'd9,  1, 0,  4'd9, 0, 0,  4'd9, 0, 0};
    vecs[17] = '{0, 1, 0, 4'd0,  1, 1,  4'd0, 1, 1,  4'd9, 1, 1}; // boundary + clr
    vecs[18] = '{0, 0, 1, 4'd9,  1, 0,  4'd9, 0, 1,  4'd9, 0, 1}; // load keeps ovf
    vecs[19] = '{0, 1, 1, 4'd4,  1, 0,  4'd4, 0, 1,  4'd4, 0, 1}; // load beats en at max
    vecs[20] = '{0, 0, 1, 4'd5,  1, 0,  4'd5, 0, 1,  4'd5, 0, 1};
    vecs[21] = '{0, 1, 0, 4'd0,  1, 0,  4'd6, 0, 1,  4'd6, 0, 1};
    vecs[22] = '{1, 1, 0, 4'd0,  1, 0,  4'd0, 0, 0,  4'd0, 0, 0}; // reset mid-count
    vecs[23] = '{0, 1, 0, 4'd0,  1, 0,  4'd1, 0, 0,  4'd1, 0, 0};
    vecs[24] = '{0, 1, 0, 4'd0,  0, 0,  4'd0, 0, 0,  4'd0, 0, 0}; // direction flip

    rst = 1'b1; en = 1'b0; load = 1'b0; din = '0; up = 1'b1; ovf_clr = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].din, vecs[i].up, vecs[i].clr);
      check_all("vec", i, vecs[i].c_w, vecs[i].tc_w, vecs[i].ovf_w,
                vecs[i].c_s, vecs[i].tc_s, vecs[i].ovf_s);
    end

    // Held up-enable at MAX_VAL: wrap keeps counting, saturate keeps tc high.
    step(0, 0, 1, 4'd9, 1, 0);
    check_all("seqA_load", 0, 9, 0, 0, 9, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 4'd0, 1, 0);
      check_all("seqA", i, i, (i == 0) ? 1 : 0, 1, 9, 1, 1);
    end

    // Full down run from MAX_VAL with ovf cleared during the load.
    step(0, 0, 1, 4'd9, 0, 1);
    check_all("seqB_load", 0, 9, 0, 0, 9, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 4'd0, 0, 0);
      if (i <= 9) check_all("seqB", i, 9 - i, 0, 0, 9 - i, 0, 0);
      else        check_all("seqB", i, 9, 1, 1, 0, 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised loadable up/down counter with programmable modulus, wrap or saturate mode, terminal-count pulse and sticky overflow flag. It generalises the team's 4-bit loadable up counter and serves as the standard event/timeout counter for control blocks. When enabled by macro, it carries its own concurrent assertions.

## Interface

**Parameters**
- `WIDTH`, default 8: counter width in bits, 2 to 32.
- `MAX_VAL`, default 2**WIDTH-1: top count value. Legal range 1 to 2**WIDTH-1. Count range is 0..MAX_VAL.
- `SAT`, default 0: boundary mode. 0 = wrap, 1 = saturate.

**Ports**
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  count enable.
- `load`  in  1  parallel load strobe.
- `din`  in  WIDTH  load value.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `ovf_clr`  in  1  clears the sticky `ovf` flag.
- `count`  out  WIDTH  registered count.
- `tc`  out  1  registered terminal-count pulse.
- `ovf`  out  1  sticky over/underflow flag.

## Operation

- Priority per edge: `rst` > `load` > `en` > hold.
- **Reset:** `count` = 0, `tc` = 0, `ovf` = 0, regardless of other inputs.
- **Load:**
  - `count` <= `din`. If `din` > `MAX_VAL`, `count` <= `MAX_VAL` (clamp).
  - Load never sets `tc` or `ovf`. `en` and `up` are ignored in that cycle.
- **Count** (`en`=1, `load`=0):
  - Up, `count` < `MAX_VAL`: `count` + 1.
  - Down, `count` > 0: `count` - 1.
- **Boundary event:** `en`=1, `load`=0, and either (`up`=1 and `count`==`MAX_VAL`) or (`up`=0 and `count`==0).
  - SAT=0: wrap. Up goes to 0; down goes to `MAX_VAL`.
  - SAT=1: `count` holds.
  - Both modes: `tc` <= 1 and `ovf` <= 1.
- **Hold** (`en`=0, `load`=0): `count` unchanged, `tc` <= 0.
- **`tc`:** equals 1 only in the cycle after a boundary event.
  - Consecutive boundary events keep it high. This is normal in SAT=1 with `en` held.
- **`ovf`:**
  - Set by a boundary event.
  - Cleared by `ovf_clr`=1 when no boundary event occurs in the same cycle. Set wins over clear.
  - Unaffected by load.
- **Arithmetic:** unsigned, modulo-free. The next value is never computed outside 0..`MAX_VAL`, and no intermediate overflows past WIDTH bits.
- Direction may change on any cycle with no penalty.

## Timing

- All outputs are registered. Inputs sampled at edge N are reflected on outputs after edge N.
- Load latency: 1 cycle.
- Count step: 1 per enabled cycle.
- `tc` is a one-cycle-late registered pulse, aligned with the wrapped or saturated `count` value.
- Reset asserted mid-count takes effect at the next edge. The first count after reset release occurs at the first edge with `rst`=0 and `en`=1.
- There is no combinational input-to-output path.

## Configuration

- **`PARAM_UPDOWN_COUNTER_SVA_EN` defined:** embedded concurrent assertions are compiled. All are disabled during `rst`:
  - `rst` |=> `count`==0 && !`ovf` && !`tc`.
  - `load` |=> `count` == min($past(`din`), `MAX_VAL`).
  - Enabled up, non-boundary |=> `count` == $past(`count`)+1. Down likewise −1.
  - !`en` && !`load` |=> $stable(`count`).
  - `count` <= `MAX_VAL` always.
  - Boundary event |=> `tc` && `ovf`.
- **Not defined:** no assertion code. RTL behaviour is identical.

## Test plan

All scenarios use WIDTH=4, MAX_VAL=9.
- Reset: `rst`=1 for 2 cycles with `en`=1, `load`=1, `din`=5 -> `count`=0, `tc`=0, `ovf`=0.
- Load clamp: `din`=13, `load`=1 -> `count`=9. Then `din`=3 -> `count`=3. No `tc` or `ovf`.
- Up wrap, SAT=0: load 8, `en`=1, `up`=1 -> `count` 9, 0, 1. `tc` high only in the cycle `count`=0. `ovf`=1 stays set until `ovf_clr`.
- Down saturate, SAT=1: load 1, `up`=0 -> `count` 0, 0, 0. `tc` high for each held cycle after the first boundary. `ovf`=1.
- Simultaneous: boundary event with `ovf_clr`=1 -> `ovf` stays 1. Then `ovf_clr` alone -> `ovf`=0. `load` with `en`=1 at `count`=9 -> loads `din`, no wrap, `tc`=0.
- Reset mid-operation: counting up at 6, `rst` for 1 cycle -> `count`=0. Next enabled cycle -> `count`=1.
